// File: rtl/ram_word_pkg.sv
// Shared constants for the ram_word front-end: access size codes,
// FSM state encoding and the size clamp helper.
package ram_word_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    // Sizes wider than one word collapse to a full word.
    function automatic logic [1:0] clamp_size(
        input logic [1:0] sz,
        input int         lb
    );
        return (int'(sz) > lb) ? 2'(lb) : sz;
    endfunction

endpackage

// File: rtl/ram_word_if.sv
// Request/response port of ram_word: valid/ready request channel
// (we, addr, size, wdata) and a one-cycle response pulse with rdata.
interface ram_word_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int BYTES      = 4
);
    logic                    req_valid_in;
    logic                    req_ready_out;
    logic                    req_we_in;
    logic [ADDR_WIDTH-1:0]   req_addr_in;
    logic [1:0]              req_size_in;
    logic [8*BYTES-1:0]      req_wdata_in;
    logic                    rsp_valid_out;
    logic [8*BYTES-1:0]      rsp_rdata_out;

    modport master (
        output req_valid_in, req_we_in, req_addr_in,
        output req_size_in, req_wdata_in,
        input  req_ready_out, rsp_valid_out, rsp_rdata_out
    );

    modport slave (
        input  req_valid_in, req_we_in, req_addr_in,
        input  req_size_in, req_wdata_in,
        output req_ready_out, rsp_valid_out, rsp_rdata_out
    );
endinterface

// File: rtl/ram_lane_rotate.sv
// Byte rotate plus size mask. LEFT=1: mask then rotate left (write
// steering); LEFT=0: rotate right then mask (read assembly).
module ram_lane_rotate #(
    parameter int BYTES = 4,
    parameter bit LEFT  = 1'b0,
    localparam int LB   = $clog2(BYTES)
) (
    input  logic [8*BYTES-1:0] data_in,
    input  logic [LB-1:0]      shift,
    input  logic [1:0]         size,
    output logic [8*BYTES-1:0] data_out,
    output logic [BYTES-1:0]   lane_mask
);
    logic [LB-1:0] src;
    logic [LB:0]   nbytes;

    always_comb begin
        data_out  = '0;
        lane_mask = '0;
        src       = '0;
        nbytes    = (LB+1)'(1) << size;
        for (int j = 0; j < BYTES; j++) begin
            if (LEFT) begin
                src = LB'(j) - shift;
                if ({1'b0, src} < nbytes) begin
                    data_out[8*j +: 8] = data_in[8*src +: 8];
                    lane_mask[j]       = 1'b1;
                end
            end else begin
                src = LB'(j) + shift;
                if ((LB+1)'(j) < nbytes) begin
                    data_out[8*j +: 8] = data_in[8*src +: 8];
                    lane_mask[j]       = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/single_port_ram_sync.sv
// Single-port RAM with synchronous read (read-first), no reset.
// Ports: clk, we, addr, din, dout (registered).
module single_port_ram_sync #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= din;
        dout <= mem[addr];
    end
endmodule

// File: rtl/ram_word.sv
// Word-wide RAM front-end: byte/half/word requests, lane steering,
// word-crossing split into two beats. Ports: clk_in, rst_in, bus.
module ram_word
    import ram_word_pkg::*;
#(
    parameter int ADDR_WIDTH = 17,
    parameter int BYTES      = 4
) (
    input  logic      clk_in,
    input  logic      rst_in,
    ram_word_if.slave bus
);
    localparam int LB = $clog2(BYTES);
    localparam int WA = ADDR_WIDTH - LB;
    localparam int DW = 8 * BYTES;

    state_t state_q, state_d;

    logic             accept;
    logic [LB-1:0]    in_off;
    logic [WA-1:0]    in_word;
    logic [1:0]       in_sz;
    logic [LB:0]      in_end;
    logic             in_split;
    logic [DW-1:0]    in_wrot;
    logic [BYTES-1:0] in_lanes;

    logic             r_we;
    logic             r_split;
    logic [WA-1:0]    r_word;
    logic [LB-1:0]    r_off;
    logic [1:0]       r_sz;
    logic [DW-1:0]    r_wrot;
    logic [BYTES-1:0] r_lanes;
    logic [DW-1:0]    stage_q;

    logic [WA-1:0]    ram_addr;
    logic [BYTES-1:0] ram_we;
    logic [DW-1:0]    ram_din;
    logic [DW-1:0]    ram_dout;
    logic [DW-1:0]    rd_merged;
    logic [DW-1:0]    rd_data;
    logic [BYTES-1:0] rd_unused;

    function automatic logic [BYTES-1:0] hi_lanes(
        input logic [LB-1:0] off
    );
        logic [BYTES-1:0] m;
        for (int i = 0; i < BYTES; i++)
            m[i] = (LB'(i) >= off);
        return m;
    endfunction

    assign accept   = bus.req_valid_in & bus.req_ready_out;
    assign in_off   = bus.req_addr_in[LB-1:0];
    assign in_word  = bus.req_addr_in[ADDR_WIDTH-1:LB];
    assign in_sz    = clamp_size(bus.req_size_in, LB);
    assign in_end   = {1'b0, in_off} + ((LB+1)'(1) << in_sz);
    assign in_split = in_end > (LB+1)'(BYTES);

    ram_lane_rotate #(.BYTES(BYTES), .LEFT(1'b1)) u_wr_rot (
        .data_in   (bus.req_wdata_in),
        .shift     (in_off),
        .size      (in_sz),
        .data_out  (in_wrot),
        .lane_mask (in_lanes)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP:
                if (accept)
                    state_d = in_split ? ST_SPLIT : ST_RESP;
                else
                    state_d = ST_IDLE;
            ST_SPLIT:
                state_d = ST_RESP;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_out = 1'b1;
        bus.rsp_valid_out = 1'b0;
        bus.rsp_rdata_out = '0;
        case (state_q)
            ST_SPLIT:
                bus.req_ready_out = 1'b0;
            ST_RESP: begin
                bus.rsp_valid_out = 1'b1;
                bus.rsp_rdata_out = r_we ? '0 : rd_data;
            end
            default: ;
        endcase
    end

    // Request context is kept for beat 1 and for response assembly.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_we    <= 1'b0;
            r_split <= 1'b0;
            r_word  <= '0;
            r_off   <= '0;
            r_sz    <= '0;
            r_wrot  <= '0;
            r_lanes <= '0;
        end else if (accept) begin
            r_we    <= bus.req_we_in;
            r_split <= in_split;
            r_word  <= in_word;
            r_off   <= in_off;
            r_sz    <= in_sz;
            r_wrot  <= in_wrot;
            r_lanes <= in_lanes;
        end
    end

    // Beat-0 read data is on the bank outputs during SPLIT.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)
            stage_q <= '0;
        else if (state_q == ST_SPLIT)
            stage_q <= ram_dout;
    end

    // Beat 1 touches the next word (wrapping), lanes below offset.
    always_comb begin
        ram_addr = in_word;
        ram_din  = in_wrot;
        ram_we   = '0;
        if (state_q == ST_SPLIT) begin
            ram_addr = r_word + WA'(1);
            ram_din  = r_wrot;
            if (r_we)
                ram_we = r_lanes & ~hi_lanes(r_off);
        end else if (accept && bus.req_we_in) begin
            ram_we = in_lanes & hi_lanes(in_off);
        end
    end

    for (genvar i = 0; i < BYTES; i++) begin : g_bank
        single_port_ram_sync #(
            .ADDR_WIDTH (WA),
            .DATA_WIDTH (8)
        ) u_bank (
            .clk  (clk_in),
            .we   (ram_we[i]),
            .addr (ram_addr),
            .din  (ram_din[8*i +: 8]),
            .dout (ram_dout[8*i +: 8])
        );
    end

    always_comb begin
        rd_merged = ram_dout;
        for (int i = 0; i < BYTES; i++)
            if (r_split && (LB'(i) >= r_off))
                rd_merged[8*i +: 8] = stage_q[8*i +: 8];
    end

    ram_lane_rotate #(.BYTES(BYTES), .LEFT(1'b0)) u_rd_rot (
        .data_in   (rd_merged),
        .shift     (r_off),
        .size      (r_sz),
        .data_out  (rd_data),
        .lane_mask (rd_unused)
    );
endmodule

// File: tb/tb_ram_word.sv
// Scoreboard bench for ram_word: directed requests push expected
// responses; a negedge monitor pops and checks data and latency.
module tb_ram_word;
    import ram_word_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ram_word_if #(.ADDR_WIDTH(17), .BYTES(4)) bus ();

    ram_word #(.ADDR_WIDTH(17), .BYTES(4)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;
    int   s0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.rsp_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(bus.rsp_valid_out), 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.nm, "_data"}, bus.rsp_rdata_out, e.data);
                check({e.nm, "_lat"}, 32'(cyc), 32'(e.due));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.nm, "_missing"}, 32'(bus.rsp_valid_out), 32'd1);
        end
    end

    task automatic send(input bit we, input logic [16:0] addr,
                        input logic [1:0] sz, input logic [31:0] wd,
                        input logic [31:0] rd_exp, input int lat,
                        input string nm, input bit push = 1'b1);
        int n = 0;
        @(negedge clk);
        bus.req_valid_in = 1'b1;
        bus.req_we_in    = we;
        bus.req_addr_in  = addr;
        bus.req_size_in  = sz;
        bus.req_wdata_in = wd;
        while (bus.req_ready_out !== 1'b1 && n < 50) begin
            if (n == 0)
                stalls++;
            @(negedge clk);
            n++;
        end
        if (bus.req_ready_out !== 1'b1) begin
            check({nm, "_accept_timeout"}, 32'(bus.req_ready_out), 32'd1);
            bus.req_valid_in = 1'b0;
            return;
        end
        if (push)
            sb.push_back('{rd_exp, cyc + lat, nm});
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid_in = 1'b0;
        bus.req_we_in    = 1'b0;
        bus.req_addr_in  = '0;
        bus.req_size_in  = '0;
        bus.req_wdata_in = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready_out), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid_out), 32'd0);
        check("rst_rdata", bus.rsp_rdata_out, 32'd0);
        rst = 1'b0;

        send(1, 17'h100, SZ_WORD, 32'h11223344, 32'h0, 1, "wr_word");
        send(0, 17'h100, SZ_WORD, 32'h0, 32'h11223344, 1, "rd_word");
        send(1, 17'h101, SZ_BYTE, 32'hAA, 32'h0, 1, "wr_byte");
        send(0, 17'h100, SZ_WORD, 32'h0, 32'h1122AA44, 1, "rd_lane");

        send(1, 17'h103, SZ_HALF, 32'hBEEF, 32'h0, 2, "wr_split");
        @(negedge clk);
        check("wr_split_ready_low", 32'(bus.req_ready_out), 32'd0);
        send(0, 17'h103, SZ_BYTE, 32'h0, 32'hEF, 1, "rd_b103");
        send(0, 17'h104, SZ_BYTE, 32'h0, 32'hBE, 1, "rd_b104");
        send(0, 17'h103, SZ_HALF, 32'h0, 32'h0000BEEF, 2, "rd_split");
        @(negedge clk);
        check("rd_split_ready_low", 32'(bus.req_ready_out), 32'd0);
        send(0, 17'h100, 2'd3, 32'h0, 32'hEF22AA44, 1, "rd_clamp");

        send(1, 17'h1FFFF, SZ_BYTE, 32'h01, 32'h0, 1, "wr_top");
        send(1, 17'h00000, SZ_WORD, 32'h0A0B0C0D, 32'h0, 1, "wr_zero");
        send(0, 17'h1FFFF, SZ_WORD, 32'h0, 32'h0B0C0D01, 2, "rd_wrap");
        idle();
        repeat (2) @(negedge clk);

        send(0, 17'h103, SZ_HALF, 32'h0, 32'h0, 2, "rd_abort", 1'b0);
        @(negedge clk);
        check("abort_ready_low", 32'(bus.req_ready_out), 32'd0);
        rst = 1'b1;
        bus.req_valid_in = 1'b0;
        @(negedge clk);
        check("abort_no_rsp", 32'(bus.rsp_valid_out), 32'd0);
        rst = 1'b0;
        check("abort_ready", 32'(bus.req_ready_out), 32'd1);
        send(0, 17'h100, SZ_WORD, 32'h0, 32'hEF22AA44, 1, "rd_after_rst");

        for (int i = 0; i < 8; i++)
            send(1, 17'h200 + 17'(4 * i), SZ_WORD,
                 32'hC0DE0000 | 32'(i), 32'h0, 1, "wr_stream");
        s0 = stalls;
        for (int i = 0; i < 8; i++)
            send(0, 17'h200 + 17'(4 * i), SZ_WORD, 32'h0,
                 32'hC0DE0000 | 32'(i), 1, "rd_stream");
        check("stream_stalls", 32'(stalls - s0), 32'd0);
        idle();
        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
